// File: rtl/add.sv
// Registered WIDTH-bit adder/subtractor: ripple chain of full-adder cells feeding
// one output register stage with carry-out, signed overflow and a valid flag.
module add #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic             w_ovf;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    // cin is passed through untouched; a true a-b needs sub=1 and cin=1 from the caller
    always_comb begin
        w_bx   = b ^ {WIDTH{sub}};
        w_sum  = '0;
        w_c    = '0;
        w_c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_sum[i]  = a[i] ^ w_bx[i] ^ w_c[i];
            w_c[i+1]  = (a[i] & w_bx[i]) | (w_c[i] & (a[i] ^ w_bx[i]));
        end
        w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_s    <= w_sum;
                r_cout <= w_c[WIDTH];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_add.sv
// Directed bench for add: exhaustive 1-bit add/sub plus 8-bit boundary,
// hold, input-isolation and reset-priority vectors.
module tb_add;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a1, b1, cin1, sub1, iv1;
    logic       s1, cout1, ovf1, ov1;

    logic [7:0] a8, b8, s8;
    logic       cin8, sub8, iv8, cout8, ovf8, ov8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    add #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .in_valid(iv1), .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
    );

    add #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .in_valid(iv8), .s(s8), .cout(cout8), .ovf(ovf8), .out_valid(ov8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] es, input logic ec,
                        input logic eo, input logic ev);
        chk({tag, ".s"},     64'(s8),    64'(es));
        chk({tag, ".cout"},  64'(cout8), 64'(ec));
        chk({tag, ".ovf"},   64'(ovf8),  64'(eo));
        chk({tag, ".valid"}, 64'(ov8),   64'(ev));
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input logic iv);
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = iv;
    endtask

    initial begin
        logic [1:0] exp_sum;
        logic       bx;

        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; sub1 = 1'b0; iv1 = 1'b1;
        drive8(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst1.s", 64'(s1), 64'd0);
        chk("rst1.cout", 64'(cout1), 64'd0);
        chk("rst1.ovf", 64'(ovf1), 64'd0);
        chk("rst1.valid", 64'(ov1), 64'd0);
        chk8("rst8", 8'h00, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        iv1 = 1'b0;
        iv8 = 1'b0;
        @(negedge clk);

        // WIDTH=1: all a/b/cin combinations in both modes
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 8; v++) begin
                a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = m[0]; iv1 = 1'b1;
                bx = (m == 1) ? ~b1 : b1;
                exp_sum = {1'b0, a1} + {1'b0, bx} + {1'b0, cin1};
                @(negedge clk);
                chk($sformatf("w1.m%0d.v%0d.s", m, v), 64'(s1), 64'(exp_sum[0]));
                chk($sformatf("w1.m%0d.v%0d.cout", m, v), 64'(cout1), 64'(exp_sum[1]));
                chk($sformatf("w1.m%0d.v%0d.ovf", m, v), 64'(ovf1), 64'(exp_sum[1] ^ cin1));
                chk($sformatf("w1.m%0d.v%0d.valid", m, v), 64'(ov1), 64'd1);
            end
        end
        iv1 = 1'b0;

        // WIDTH=8 directed boundary vectors
        drive8(8'h05, 8'h07, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk8("sub_05_07", 8'hFE, 1'b0, 1'b0, 1'b1);
        drive8(8'h80, 8'h01, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk8("sub_80_01", 8'h7F, 1'b1, 1'b1, 1'b1);
        drive8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk8("add_FF_01", 8'h00, 1'b1, 1'b0, 1'b1);
        drive8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk8("add_7F_01", 8'h80, 1'b0, 1'b1, 1'b1);
        drive8(8'h10, 8'h03, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk8("onesc_10_03", 8'h0C, 1'b1, 1'b0, 1'b1);

        // valid, valid, then idle with changed operands: result must hold
        drive8(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk8("bb1", 8'h03, 1'b0, 1'b0, 1'b1);
        drive8(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk8("bb2", 8'h30, 1'b0, 1'b0, 1'b1);
        drive8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk8("hold", 8'h30, 1'b0, 1'b0, 1'b0);

        // operands changing between edges must not reach the outputs
        drive8(8'h22, 8'h11, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        drive8(8'hF0, 8'hF0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk8("iso", 8'h33, 1'b0, 1'b0, 1'b1);

        // reset wins over a simultaneous valid input
        rst_n = 1'b0;
        drive8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk8("rst_prio", 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk8("post_rst", 8'h02, 1'b0, 1'b0, 1'b1);
        drive8(8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk8("post_rst_hold", 8'h02, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
